// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline latch: occupancy state codes,
// default bubble instruction word and bus-width helper.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    function automatic int bus_width(input int data_width, input int num_fields);
        return data_width * num_fields;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One latch entry: a wide data register that loads only when told to.
// Clears asynchronously so no stale word survives reset.
module pipe_entry #(
    parameter int WIDTH = 96
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// Valid/ready pipeline stage latch with optional two-entry skid, flush and NOP bubbles.
// One cycle latency; with SKID=1 in_ready is registered, with SKID=0 it follows out_ready.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_FIELDS = 3,
    parameter int                    NOP_FIELD  = 0,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = DATA_WIDTH'(NOP_DEFAULT),
    parameter bit                    SKID       = 1'b1,
    localparam int                   W          = bus_width(DATA_WIDTH, NUM_FIELDS)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         load_main;
    logic         main_from_skid;
    logic         fire_in;
    logic         fire_out;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic [W-1:0] bubble;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign in_ready  = SKID ? (state != ST_TWO) : (!out_valid || out_ready);
    assign fire_in   = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (fire_in) begin
                    load_main = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (fire_in && fire_out) begin
                    load_main = 1'b1;
                end else if (fire_in && SKID) begin
                    state_nxt = ST_TWO;
                end else if (fire_out) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (fire_out) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush wins over every transfer, including a same-cycle accept.
        if (flush) begin
            state_nxt = ST_EMPTY;
            load_main = 1'b0;
        end
    end

    pipe_entry #(.WIDTH(W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (load_main),
        .d     (main_from_skid ? skid_q : in_data),
        .q     (main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.WIDTH(W)) u_skid (
                .clock (clock),
                .reset (reset),
                .load  (!flush && (state == ST_ONE) && fire_in && !fire_out),
                .d     (in_data),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    always_comb begin
        bubble = '0;
        bubble[NOP_FIELD*DATA_WIDTH +: DATA_WIDTH] = NOP_VALUE;
    end

    assign out_data = out_valid ? main_q : bubble;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Drives a skid, a no-skid and a custom-NOP instance with shared stimulus and
// compares each against a queue-based FIFO model of the latch.
module tb_pipe_stage_latch;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int W  = DW * NF;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         flush;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         ir1, ov1, ir0, ov0, irn, ovn;
    logic [W-1:0] od1, od0, odn;
    logic [1:0]   oc1, oc0, ocn;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    always #5 clock = ~clock;

    pipe_stage_latch u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .occupancy(oc1)
    );

    pipe_stage_latch #(.SKID(1'b0)) u_dut_noskid (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .occupancy(oc0)
    );

    pipe_stage_latch #(.NOP_FIELD(1), .NOP_VALUE(32'hFFFF0000)) u_dut_nop (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(irn),
        .in_data(in_data), .flush(flush), .out_valid(ovn), .out_ready(out_ready),
        .out_data(odn), .occupancy(ocn)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check shortly after, then advance the model.
    task automatic cycle(input logic rst, input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic fl);
        logic         r1;
        logic         r0;
        logic [W-1:0] bn;
        @(negedge clock);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (rst) begin
            q1.delete();
            q0.delete();
        end
        #1;
        bn = '0;
        bn[63:32] = 32'hFFFF0000;
        r1 = (q1.size() < 2);
        r0 = (q0.size() == 0) || ordy;

        chk("skid_in_ready",  W'(ir1), W'(r1));
        chk("skid_out_valid", W'(ov1), W'(q1.size() != 0));
        chk("skid_occupancy", W'(oc1), W'(q1.size()));
        chk("skid_out_data",  od1, (q1.size() != 0) ? q1[0] : '0);

        chk("nop_out_valid",  W'(ovn), W'(q1.size() != 0));
        chk("nop_occupancy",  W'(ocn), W'(q1.size()));
        chk("nop_out_data",   odn, (q1.size() != 0) ? q1[0] : bn);

        chk("noskid_in_ready",  W'(ir0), W'(r0));
        chk("noskid_out_valid", W'(ov0), W'(q0.size() != 0));
        chk("noskid_occupancy", W'(oc0), W'(q0.size()));
        chk("noskid_out_data",  od0, (q0.size() != 0) ? q0[0] : '0);

        if (!rst) begin
            if (fl) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && ordy) void'(q1.pop_front());
                if (iv && r1) q1.push_back(d);
                if (q0.size() != 0 && ordy) void'(q0.pop_front());
                if (iv && r0) q0.push_back(d);
            end
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset held while upstream keeps offering an entry.
        repeat (3) cycle(1'b1, 1'b1, {32'h33, 32'h22, 32'h11}, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Streaming with the consumer always ready.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, rnd_data(), 1'b1, 1'b0);

        // Mid-stream stall, then release and drain.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Fill to two entries, then flush with a live input offered.
        cycle(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, rnd_data(), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, {32'hDEAD, 32'hBEEF, 32'hF00D}, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush and mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  rnd_data(),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
